// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares one L2 CPU-side request port between the L1 I-cache
// (port 0) and the L1 D-cache (port 1). The winning request is registered onto
// the l2_* outputs and held until l2_ready_i. The returned line is then steered
// back to the owner in the same cycle.
// Optional build macro ARB_FIXED_PRIO_EN: port 1 always wins a tie, and no
// round-robin pointer is built. When the macro is undefined, ties go to the
// port that the round-robin pointer favours.

// Per-port response steering: raises the completion pulse for the owner and
// remembers the last line delivered to this port.
module l2_rsp_port #(
  parameter int DATA_WIDTH = 128,
  parameter bit PORT_ID    = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  done_i,
  input  logic                  owner_i,
  input  logic [DATA_WIDTH-1:0] l2_data_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_ready_o
);
  logic [DATA_WIDTH-1:0] last_q;

  assign rsp_ready_o = done_i && (owner_i == PORT_ID);
  assign rsp_data_o  = rsp_ready_o ? l2_data_i : last_q;

  // Keep the last line routed here so the output is stable outside the pulse
  always_ff @(posedge clk_i) begin
    if (rst_i)            last_q <= '0;
    else if (rsp_ready_o) last_q <= l2_data_i;
  end
endmodule

module l2_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  input  logic                  req0_rw_i,
  input  logic                  req0_valid_i,
  output logic [DATA_WIDTH-1:0] rsp0_data_o,
  output logic                  rsp0_ready_o,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  input  logic                  req1_rw_i,
  input  logic                  req1_valid_i,
  output logic [DATA_WIDTH-1:0] rsp1_data_o,
  output logic                  rsp1_ready_o,
  output logic [ADDR_WIDTH-1:0] l2_addr_o,
  output logic [DATA_WIDTH-1:0] l2_data_o,
  output logic                  l2_rw_o,
  output logic                  l2_valid_o,
  input  logic [DATA_WIDTH-1:0] l2_data_i,
  input  logic                  l2_ready_i,
  output logic                  owner_o
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state;

  // Requests gathered into packed per-port arrays so the grant can index them
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_PORTS-1:0]                 req_rw;
  logic [NUM_PORTS-1:0]                 req_valid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rsp_data;
  logic [NUM_PORTS-1:0]                 rsp_ready;

  assign req_addr  = {req1_addr_i,  req0_addr_i};
  assign req_data  = {req1_data_i,  req0_data_i};
  assign req_rw    = {req1_rw_i,    req0_rw_i};
  assign req_valid = {req1_valid_i, req0_valid_i};

  logic gnt_any;
  logic gnt_sel;
  logic tie_sel;
  logic done;

`ifdef ARB_FIXED_PRIO_EN
  // D-cache always wins a tie; the I-cache can starve
  assign tie_sel = 1'b1;
`else
  logic rr_ptr;  // port favoured on the next tie

  assign tie_sel = rr_ptr;

  // Hand the tie to the non-owner once a transaction completes
  always_ff @(posedge clk_i) begin
    if (rst_i)                    rr_ptr <= 1'b0;
    else if (state == BUSY && l2_ready_i) rr_ptr <= ~owner_o;
  end
`endif

  // Pick a winner: a lone requester wins; a tie goes to the favoured port
  always_comb begin
    gnt_any = |req_valid;
    gnt_sel = (&req_valid) ? tie_sel : req_valid[1];
  end

  // A completion during a reset cycle is abandoned, so no pulse is issued
  assign done = (state == BUSY) && l2_ready_i && !rst_i;

  // Arbitration FSM; all l2_* outputs and the owner are registered here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      l2_valid_o <= 1'b0;
      l2_addr_o  <= '0;
      l2_data_o  <= '0;
      l2_rw_o    <= 1'b0;
      owner_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          l2_addr_o  <= req_addr[gnt_sel];
          l2_data_o  <= req_data[gnt_sel];
          l2_rw_o    <= req_rw[gnt_sel];
          owner_o    <= gnt_sel;
          l2_valid_o <= 1'b1;
          state      <= BUSY;
        end
        BUSY: if (l2_ready_i) begin
          l2_valid_o <= 1'b0;
          state      <= DONE;
        end
        // Bubble cycle so the finished requester can drop valid
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    l2_rsp_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .PORT_ID   (p == 1)
    ) u_rsp (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .done_i     (done),
      .owner_i    (owner_o),
      .l2_data_i  (l2_data_i),
      .rsp_data_o (rsp_data[p]),
      .rsp_ready_o(rsp_ready[p])
    );
  end

  assign rsp0_data_o  = rsp_data[0];
  assign rsp1_data_o  = rsp_data[1];
  assign rsp0_ready_o = rsp_ready[0];
  assign rsp1_ready_o = rsp_ready[1];
endmodule
